conv_input_fetch: RTL and testbench
===================================

# conv_input_fetch

Read-side initiator for the 8K×32 convolution input SRAM. It fetches one 4×4 ifmap tile and the 3×3 weight set for two channels, unpacks each 32-bit word into channel 1 (bits 15:0) and channel 2 (bits 31:16), and presents the assembled operands to the convolution datapath through a valid/ready handshake. It sits between the input SRAM read port and the conv PE array, and it owns all SRAM read addressing.

## Interface
- NUM_TILES, default 30: number of valid ifmap tiles; legal tile_idx range is 0..NUM_TILES-1.
- IFMAP_ADDR_BASE, default 1: SRAM word address of element 0 of tile 0. Tile t occupies addresses IFMAP_ADDR_BASE+16t .. +16t+15.
- WEIGHT_ADDR_BASE, default 7680: SRAM word address of weight element 0. Weights occupy 9 consecutive words.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  fetch request; sampled only in IDLE.
- tile_idx  in  9  tile to fetch; sampled together with start.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when a start is rejected.
- sram_csbn  out  1  SRAM read strobe. The SRAM updates rdata on edges where this is 1. Driven 1 only on issue cycles.
- sram_raddr  out  13  SRAM read address, registered.
- sram_rdata  in  32  SRAM read data, valid one cycle after the issue edge.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- ifmap_1, ifmap_2  out  16×16 packed  tile elements 0..15, row-major; element k comes from address base+k.
- weight_1, weight_2  out  9×16 packed  weights 0..8.

## Operation
- FSM states: IDLE, FETCH_W, FETCH_I, WAIT_LAST, HOLD.
- IDLE to FETCH_W: start=1 and tile_idx<NUM_TILES. The tile_idx is latched.
- If tile_idx ≥ NUM_TILES, the request is rejected: err pulses for 1 cycle and the FSM stays in IDLE.
- FETCH_W issues 9 reads at WEIGHT_ADDR_BASE+0..8, one per cycle, then moves to FETCH_I.
- FETCH_I issues 16 reads at IFMAP_ADDR_BASE+16·tile+0..15, then moves to WAIT_LAST.
- WAIT_LAST holds for one cycle until the final word is captured, then moves to HOLD with out_valid=1.
- Capture pipeline:
  - Each issue carries a tag (weight/ifmap, index 0..15) that is delayed two edges.
  - The word issued at edge E is written into its destination slot at edge E+2.
  - Captures overlap with later issues; the FSM never stalls between them.
- HOLD: output registers are frozen while out_valid=1. The FSM returns to IDLE on the edge where out_ready=1.
- start arriving in any state other than IDLE is ignored, with no err pulse and no effect.
- sram_csbn=0 in IDLE, WAIT_LAST and HOLD. sram_raddr holds its last value while not issuing.
- Address arithmetic is 13-bit unsigned with no wrap checking. Parameters are chosen so base+16·(NUM_TILES-1)+15 < WEIGHT_ADDR_BASE.
- Reset (rst_n=0 at an edge), from any state including mid-fetch:
  - FSM returns to IDLE and all in-flight tags are discarded.
  - busy=0, err=0, out_valid=0, sram_csbn=0, sram_raddr=0.
  - ifmap_1/2 and weight_1/2 are cleared to 0.
  - The weight-cache valid flag is cleared.

## Timing
- The edge that samples start is E0. Issues occur at edges E0 .. E(n-1).
- out_valid rises at edge E(n+1), i.e. it is visible n+1 cycles after the start edge.
- With weights fetched, n=25, so out_valid rises after 26 cycles. With weights cached, n=16, so out_valid rises after 17 cycles.
- busy rises at E0 and falls at the out_ready handshake edge.
- Minimum IDLE dwell between bundles is one cycle: a new start is sampled on the cycle after the handshake edge.

## Configuration
- WEIGHT_CACHE_EN defined:
  - A weight_valid flag is set after the first complete weight fetch.
  - Later starts skip FETCH_W and go directly to FETCH_I.
  - weight_1/weight_2 retain their cached contents.
  - The flag clears only on reset.
- WEIGHT_CACHE_EN undefined: every start fetches weights through FETCH_W.

## Test plan
- SRAM model with word@7680+k = {k+16'h100, k}, start tile_idx=0 → exactly 25 issues (7680..7688, then 1..16); out_valid at cycle 26; weight_1[8]=8, weight_2[8]=16'h108.
- Tile 3 with word@a = {~a[15:0], a[15:0]} → ifmap_1[0]=49, ifmap_1[15]=64, ifmap_2[0]=~49; sram_csbn=1 on exactly the issue cycles.
- out_ready held 0 for 10 cycles after out_valid → outputs stable and busy=1; start pulsed during HOLD is ignored; handshake occurs on the first out_ready=1 edge.
- start with tile_idx=30 → err high for 1 cycle, no sram_csbn activity, busy stays 0.
- rst_n=0 during FETCH_I index 7 → next cycle all outputs 0 and FSM idle; a following start produces a correct bundle.
- With WEIGHT_CACHE_EN defined, two back-to-back fetches → second has 16 issues and out_valid at cycle 17, with weights unchanged. Without it, both fetches have 25 issues.

Source files
------------

// File: rtl/conv_input_fetch.sv
// rtl/conv_input_fetch.sv - conv input SRAM read initiator; optional macro WEIGHT_CACHE_EN skips repeat weight fetches
module conv_input_fetch #(
   parameter int NUM_TILES        = 30,
   parameter int IFMAP_ADDR_BASE  = 1,
   parameter int WEIGHT_ADDR_BASE = 7680
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [8:0]     tile_idx,
   output logic           busy,
   output logic           err,
   output logic           sram_csbn,
   output logic [12:0]    sram_raddr,
   input  logic [31:0]    sram_rdata,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [255:0]   ifmap_1,
   output logic [255:0]   ifmap_2,
   output logic [143:0]   weight_1,
   output logic [143:0]   weight_2
);

   localparam logic [12:0] IBASE = 13'(IFMAP_ADDR_BASE);
   localparam logic [12:0] WBASE = 13'(WEIGHT_ADDR_BASE);
   localparam logic [9:0]  NT    = 10'(NUM_TILES);

   typedef enum logic [2:0] {IDLE, FETCH_W, FETCH_I, WAIT_LAST, HOLD} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [8:0]  tile_q, tile_d;
   logic        issue, issue_w, err_d;
   logic [3:0]  issue_idx;
   logic [12:0] issue_addr;
   logic        tag1_v, tag1_w, tag2_v, tag2_w;
   logic [3:0]  tag1_idx, tag2_idx;
   logic        weight_valid;
   logic        last_capture;
   logic [12:0] tile_base_q, tile_base_in;

   logic [15:0] ifm1_q [16];
   logic [15:0] ifm2_q [16];
   logic [15:0] w1_q [9];
   logic [15:0] w2_q [9];

   assign tile_base_q  = IBASE + {tile_q, 4'b0000};
   assign tile_base_in = IBASE + {tile_idx, 4'b0000};
   assign last_capture = tag2_v && !tag2_w && (tag2_idx == 4'd15);

   // FSM state, issue counter and latched tile
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         tile_q  <= 9'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tile_q  <= tile_d;
      end
   end

   // next state and the read to issue on this edge
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tile_d     = tile_q;
      issue      = 1'b0;
      issue_w    = 1'b0;
      issue_idx  = 4'd0;
      issue_addr = sram_raddr;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if ({1'b0, tile_idx} < NT) begin
                  tile_d = tile_idx;
                  issue  = 1'b1;
                  cnt_d  = 4'd1;
                  if (weight_valid) begin
                     issue_addr = tile_base_in;
                     state_d    = FETCH_I;
                  end else begin
                     issue_w    = 1'b1;
                     issue_addr = WBASE;
                     state_d    = FETCH_W;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FETCH_W: begin
            issue      = 1'b1;
            issue_w    = 1'b1;
            issue_idx  = cnt_q;
            issue_addr = WBASE + {9'd0, cnt_q};
            if (cnt_q == 4'd8) begin
               cnt_d   = 4'd0;
               state_d = FETCH_I;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         FETCH_I: begin
            issue      = 1'b1;
            issue_idx  = cnt_q;
            issue_addr = tile_base_q + {9'd0, cnt_q};
            if (cnt_q == 4'd15) begin
               cnt_d   = 4'd0;
               state_d = WAIT_LAST;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WAIT_LAST: begin
            if (last_capture) state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // SRAM strobe/address, reject pulse and the two-stage tag pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sram_csbn  <= 1'b0;
         sram_raddr <= 13'd0;
         err        <= 1'b0;
         tag1_v     <= 1'b0;
         tag1_w     <= 1'b0;
         tag1_idx   <= 4'd0;
         tag2_v     <= 1'b0;
         tag2_w     <= 1'b0;
         tag2_idx   <= 4'd0;
      end else begin
         sram_csbn <= issue;
         if (issue) sram_raddr <= issue_addr;
         err      <= err_d;
         tag1_v   <= issue;
         tag1_w   <= issue_w;
         tag1_idx <= issue_idx;
         tag2_v   <= tag1_v;
         tag2_w   <= tag1_w;
         tag2_idx <= tag1_idx;
      end
   end

   // write returning words into their operand slots, split into the two channels
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) begin
            ifm1_q[k] <= 16'd0;
            ifm2_q[k] <= 16'd0;
         end
         for (int k = 0; k < 9; k++) begin
            w1_q[k] <= 16'd0;
            w2_q[k] <= 16'd0;
         end
      end else if (tag2_v) begin
         if (tag2_w) begin
            w1_q[tag2_idx] <= sram_rdata[15:0];
            w2_q[tag2_idx] <= sram_rdata[31:16];
         end else begin
            ifm1_q[tag2_idx] <= sram_rdata[15:0];
            ifm2_q[tag2_idx] <= sram_rdata[31:16];
         end
      end
   end

`ifdef WEIGHT_CACHE_EN
   logic weight_done;
   assign weight_done = tag2_v && tag2_w && (tag2_idx == 4'd8);

   // weights stay resident once a full set has landed; only reset drops them
   always_ff @(posedge clk) begin
      if (!rst_n) weight_valid <= 1'b0;
      else if (weight_done) weight_valid <= 1'b1;
   end
`else
   assign weight_valid = 1'b0;
`endif

   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == HOLD);

   for (genvar k = 0; k < 16; k++) begin : g_ifm
      assign ifmap_1[16*k +: 16] = ifm1_q[k];
      assign ifmap_2[16*k +: 16] = ifm2_q[k];
   end

   for (genvar k = 0; k < 9; k++) begin : g_wgt
      assign weight_1[16*k +: 16] = w1_q[k];
      assign weight_2[16*k +: 16] = w2_q[k];
   end

endmodule

// File: tb/tb_conv_input_fetch.sv
// tb/tb_conv_input_fetch.sv - scoreboard bench for conv_input_fetch
module tb_conv_input_fetch;

   localparam int NT = 30;
   localparam int IB = 1;
   localparam int WB = 7680;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [8:0]     tile_idx = 9'd0;
   logic           busy, err, sram_csbn, out_valid;
   logic           out_ready = 1'b0;
   logic [12:0]    sram_raddr;
   logic [31:0]    sram_rdata;
   logic [255:0]   ifmap_1, ifmap_2;
   logic [143:0]   weight_1, weight_2;

   typedef struct {
      logic [255:0] i1;
      logic [255:0] i2;
      logic [143:0] w1;
      logic [143:0] w2;
      int           n;
   } exp_t;

   exp_t        sb_q[$];
   logic [12:0] addr_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          issue_cnt = 0;
   bit          chk_addr = 1'b1;
   bit          w_loaded = 1'b0;

   conv_input_fetch dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tile_idx(tile_idx),
      .busy(busy), .err(err), .sram_csbn(sram_csbn), .sram_raddr(sram_raddr),
      .sram_rdata(sram_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .ifmap_1(ifmap_1), .ifmap_2(ifmap_2), .weight_1(weight_1), .weight_2(weight_2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [12:0] a);
      logic [15:0] k;
      logic [15:0] a16;
      if (a >= 13'(WB)) begin
         k = 16'(a - 13'(WB));
         return {k + 16'h0100, k};
      end
      a16 = {3'b000, a};
      return {~a16, a16};
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) if (sram_csbn === 1'b1) sram_rdata <= mem_word(sram_raddr);
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sram_csbn === 1'b1) begin
         issue_cnt++;
         if (chk_addr) begin
            if (addr_q.size() == 0) check("extra_issue", 1, 0);
            else check("issue_addr", sram_raddr, addr_q.pop_front());
         end
      end
   end

   task automatic push_fetch(input int t);
      exp_t        e;
      bit          cached;
      logic [15:0] a16;
      cached = 1'b0;
`ifdef WEIGHT_CACHE_EN
      cached = w_loaded;
`endif
      e.n = cached ? 16 : 25;
      if (!cached)
         for (int k = 0; k < 9; k++) addr_q.push_back(13'(WB + k));
      for (int k = 0; k < 16; k++) begin
         addr_q.push_back(13'(IB + 16*t + k));
         a16 = 16'(IB + 16*t + k);
         e.i1[16*k +: 16] = a16;
         e.i2[16*k +: 16] = ~a16;
      end
      for (int k = 0; k < 9; k++) begin
         e.w1[16*k +: 16] = 16'(k);
         e.w2[16*k +: 16] = 16'(k + 16'h0100);
      end
      sb_q.push_back(e);
      w_loaded = 1'b1;
   endtask

   task automatic run_fetch(input int t, input int hold);
      exp_t e;
      int   t0;
      bit   got;
      push_fetch(t);
      issue_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      tile_idx = 9'(t);
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
      check("busy_rise", busy, 1);
      got = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("valid_seen", got, 1);
      e = sb_q.pop_front();
      check("latency", cyc - t0, e.n + 1);
      check("issue_count", issue_cnt, e.n);
      check("addr_left", addr_q.size(), 0);
      check("ifmap_1", ifmap_1, e.i1);
      check("ifmap_2", ifmap_2, e.i2);
      check("weight_1", weight_1, e.w1);
      check("weight_2", weight_2, e.w2);
      for (int i = 0; i < hold; i++) begin
         start = (i == 3);
         tile_idx = 9'd2;
         @(negedge clk);
         check("hold_busy", busy, 1);
         check("hold_valid", out_valid, 1);
         check("hold_ifmap_1", ifmap_1, e.i1);
         check("hold_weight_2", weight_2, e.w2);
      end
      start = 1'b0;
      check("hold_no_issue", issue_cnt, e.n);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hs_valid", out_valid, 0);
      check("hs_busy", busy, 0);
   endtask

   initial begin
      bit found;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_valid", out_valid, 0);
      check("rst_csbn", sram_csbn, 0);
      check("rst_raddr", sram_raddr, 0);
      check("rst_ifmap_1", ifmap_1, 0);
      check("rst_weight_2", weight_2, 0);
      rst_n = 1'b1;

      run_fetch(0, 0);
      check("t0_w1_8", weight_1[143:128], 16'd8);
      check("t0_w2_8", weight_2[143:128], 16'h0108);

      run_fetch(3, 10);
      check("t3_i1_0", ifmap_1[15:0], 16'd49);
      check("t3_i1_15", ifmap_1[255:240], 16'd64);
      check("t3_i2_0", ifmap_2[15:0], 16'hFFCE);

      for (int r = 0; r < 2; r++) begin
         issue_cnt = 0;
         @(negedge clk);
         start = 1'b1;
         tile_idx = (r == 0) ? 9'd30 : 9'd511;
         @(posedge clk);
         #1;
         start = 1'b0;
         check("rej_err_hi", err, 1);
         check("rej_busy", busy, 0);
         @(posedge clk);
         #1;
         check("rej_err_lo", err, 0);
         check("rej_busy2", busy, 0);
         @(negedge clk);
         check("rej_issues", issue_cnt, 0);
      end

      chk_addr = 1'b0;
      @(negedge clk);
      start = 1'b1;
      tile_idx = 9'd5;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (sram_csbn === 1'b1 && sram_raddr === 13'(IB + 80 + 7)) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("mid_fetch_seen", found, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_valid", out_valid, 0);
      check("mrst_csbn", sram_csbn, 0);
      check("mrst_raddr", sram_raddr, 0);
      check("mrst_ifmap_1", ifmap_1, 0);
      check("mrst_ifmap_2", ifmap_2, 0);
      check("mrst_weight_1", weight_1, 0);
      rst_n = 1'b1;
      addr_q.delete();
      sb_q.delete();
      w_loaded = 1'b0;
      chk_addr = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("mrst_no_tags", ifmap_1, 0);

      run_fetch(29, 0);
      run_fetch(7, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
